// File: rtl/fb_scanout.sv
// fb_scanout: streams one 256-pixel frame out of a framebuffer.
// The framebuffer has a synchronous read port.
// Pixels leave on a valid/ready interface with start-of-frame, end-of-line and end-of-frame markers.
// At most two pixels are held at a time, counting buffered ones and reads still in flight.
module fb_scanout #(
   parameter int LINE_LEN = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [7:0] fb_addr,
   input  logic [7:0] fb_dout,
   output logic [7:0] px_data,
   output logic       px_valid,
   input  logic       px_ready,
   output logic       px_sof,
   output logic       px_eol,
   output logic       px_eof
);

   localparam int         LINE_BITS = $clog2(LINE_LEN);
   localparam logic [8:0] LAST_PX   = 9'd255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;

   // Nine-bit indices: rd_idx reaching 256 means every read has been issued
   logic [8:0] rd_idx_q, rd_idx_d;
   logic [8:0] px_idx_q, px_idx_d;

   logic [7:0] addr_q;          // address of the most recently issued read
   logic       inflight_q;      // a read was issued last cycle; its data is on fb_dout now
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;         // buffered pixels, 0..2
   logic [7:0] entry_w [2];

   logic       accept;
   logic       push;
   logic       pop;
   logic       issue;
   logic       last_px;
   logic [2:0] occ_after;

   assign accept   = (state_q == IDLE) && start;
   assign push     = inflight_q;
   assign px_valid = (count_q != 2'd0);
   assign pop      = px_valid && px_ready;

   // The slot freed by a pixel leaving this cycle is already counted as free.
   // This gives one pixel per clock with a one-cycle read latency and only two slots.
   assign occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = (state_q == SCAN) && !rd_idx_q[8] && (occ_after < 3'd2);
   assign last_px   = pop && (px_idx_q == LAST_PX);

   // The address is presented in the issue cycle and then held until the next issue
   assign fb_addr = issue ? rd_idx_q[7:0] : addr_q;

   // The head of the buffer drives the pixel port; markers derive from the head's index
   assign px_data = entry_w[rd_ptr_q];
   assign px_sof  = px_valid && (px_idx_q == 9'd0);
   assign px_eol  = px_valid && (&px_idx_q[LINE_BITS-1:0]);
   assign px_eof  = px_valid && (px_idx_q == LAST_PX);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and status outputs: start is only heard in IDLE
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            busy = 1'b1;
            if (last_px) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Index next-state: both clear when a frame is accepted.
   // Otherwise they advance on a read issue or a pixel transfer.
   always_comb begin
      rd_idx_d = rd_idx_q;
      px_idx_d = px_idx_q;
      if (accept) begin
         rd_idx_d = 9'd0;
         px_idx_d = 9'd0;
      end else begin
         if (issue) begin
            rd_idx_d = rd_idx_q + 9'd1;
         end
         if (pop) begin
            px_idx_d = px_idx_q + 9'd1;
         end
      end
   end

   // Index, held-address and in-flight registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_idx_q   <= 9'd0;
         px_idx_q   <= 9'd0;
         addr_q     <= 8'd0;
         inflight_q <= 1'b0;
      end else begin
         rd_idx_q   <= rd_idx_d;
         px_idx_q   <= px_idx_d;
         inflight_q <= issue;
         if (issue) begin
            addr_q <= rd_idx_q[7:0];
         end
      end
   end

   // Buffer pointers and occupancy: a push and a pop in the same cycle both take effect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (accept) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_q ^ push;
         rd_ptr_q <= rd_ptr_q ^ pop;
         count_q  <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Two buffer slots; returning read data lands in the slot under the write pointer
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         logic [7:0] entry_q;

         // Capture fb_dout into this slot when a read completes and the slot is selected
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               entry_q <= 8'd0;
            end else if (push && (wr_ptr_q == 1'(gi))) begin
               entry_q <= fb_dout;
            end
         end

         assign entry_w[gi] = entry_q;
      end
   endgenerate

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: randomized frames against a reference model of the expected pixel stream.
// The expected stream is the framebuffer contents in address order.
// Each pixel's markers come from its index. A LINE_LEN=256 copy runs in lockstep.
module tb_fb_scanout;

   localparam int LL = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       px_ready;
   logic [7:0] fb_dout;

   logic       busy, done, px_valid, px_sof, px_eol, px_eof;
   logic [7:0] fb_addr, px_data;

   logic       b_busy, b_done, b_px_valid, b_px_sof, b_px_eol, b_px_eof;
   logic [7:0] b_fb_addr, b_px_data;

   logic [7:0] mem [256];

   int         tests_run    = 0;
   int         tests_failed = 0;
   int         exp_idx      = 0;
   int         done_cnt     = 0;
   int         frame_no     = 0;
   int         seen_frame   = 0;
   int         ready_mode   = 0;
   logic       prev_stall   = 1'b0;
   logic       prev_last    = 1'b0;
   logic       now_last;
   logic [10:0] prev_vec    = '0;

   always #5 clk = ~clk;

   // Synchronous-read framebuffer model
   always @(posedge clk) fb_dout <= mem[fb_addr];

   fb_scanout #(.LINE_LEN(LL)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .fb_addr(fb_addr), .fb_dout(fb_dout), .px_data(px_data),
      .px_valid(px_valid), .px_ready(px_ready), .px_sof(px_sof),
      .px_eol(px_eol), .px_eof(px_eof)
   );

   fb_scanout #(.LINE_LEN(256)) dut_b (
      .clk(clk), .rst(rst), .start(start), .busy(b_busy), .done(b_done),
      .fb_addr(b_fb_addr), .fb_dout(fb_dout), .px_data(b_px_data),
      .px_valid(b_px_valid), .px_ready(px_ready), .px_sof(b_px_sof),
      .px_eol(b_px_eol), .px_eof(b_px_eof)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      tests_run++;
      if (got != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, ahead of the rising edge where transfers happen
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         prev_last  = 1'b0;
      end else begin
         if (frame_no != seen_frame) begin
            seen_frame = frame_no;
            exp_idx    = 0;
            done_cnt   = 0;
            prev_stall = 1'b0;
            prev_last  = 1'b0;
         end
         check_eq("b_ctrl_match", int'({b_busy, b_done, b_fb_addr}), int'({busy, done, fb_addr}));
         if (busy) begin
            check_eq("addr_lead_ok", int'(int'(fb_addr) <= exp_idx + 2), 1);
         end
         if (busy && ready_mode != 1 && exp_idx >= 1 && exp_idx <= 255) begin
            check_eq("no_gap_valid", int'(px_valid), 1);
         end
         if (px_valid && prev_stall) begin
            check_eq("stall_stable", int'({px_data, px_sof, px_eol, px_eof}), int'(prev_vec));
         end
         if (done) begin
            done_cnt++;
            check_eq("done_after_last", int'(prev_last), 1);
         end
         now_last = 1'b0;
         if (px_valid && px_ready) begin
            if (exp_idx > 255) begin
               check_eq("extra_pixel", exp_idx, 255);
            end else begin
               check_eq("px_data", int'(px_data), int'(mem[exp_idx]));
               check_eq("px_sof", int'(px_sof), int'(exp_idx == 0));
               check_eq("px_eol", int'(px_eol), int'((exp_idx % LL) == LL - 1));
               check_eq("px_eof", int'(px_eof), int'(exp_idx == 255));
               check_eq("b_px_data", int'(b_px_data), int'(mem[exp_idx]));
               check_eq("b_px_eol", int'(b_px_eol), int'(exp_idx == 255));
               check_eq("b_px_eof", int'(b_px_eof), int'(exp_idx == 255));
               now_last = 1'(exp_idx == 255);
            end
            exp_idx++;
         end
         prev_stall = px_valid && !px_ready;
         prev_vec   = {px_data, px_sof, px_eol, px_eof};
         prev_last  = now_last;
      end
   end

   // One frame.
   // Modes: 0 = ready always high, 1 = random ready, 2 = ready low for the first 20 cycles.
   // restart_at pulses start while that pixel is pending.
   // abort_at asserts reset mid-frame once that many pixels have been taken.
   task automatic run_frame(input int mode, input int restart_at, input int abort_at, input bit ramp);
      int cyc;
      int first_v;
      bit restarted;
      bit finished;
      for (int i = 0; i < 256; i++) begin
         mem[i] = ramp ? 8'(i) : 8'($urandom);
      end
      ready_mode = mode;
      px_ready   = (mode == 2) ? 1'b0 : 1'b1;
      frame_no++;
      start = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      cyc       = 0;
      first_v   = -1;
      restarted = 1'b0;
      finished  = 1'b0;
      while (!finished && cyc < 3000) begin
         if (first_v < 0 && px_valid) first_v = cyc;
         if (abort_at >= 0 && exp_idx >= abort_at) begin
            #2 rst = 1'b1;
            #1;
            check_eq("abort_valid", int'(px_valid), 0);
            check_eq("abort_busy", int'(busy), 0);
            check_eq("abort_addr", int'(fb_addr), 0);
            check_eq("abort_flags", int'({px_sof, px_eol, px_eof, done}), 0);
            @(posedge clk); #1;
            @(negedge clk);
            rst      = 1'b0;
            px_ready = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            check_eq("abort_idle_busy", int'(busy), 0);
            check_eq("abort_no_done", done_cnt, 0);
            $display("[TB] frame %0d mode %0d: aborted by reset after %0d pixels", frame_no, mode, exp_idx);
            return;
         end
         if (done) begin
            finished = 1'b1;
         end else begin
            if (mode == 2 && cyc == 20) begin
               check_eq("stall_addr", int'(fb_addr), 1);
               check_eq("stall_valid", int'(px_valid), 1);
               check_eq("stall_data", int'(px_data), int'(mem[0]));
            end
            if (mode == 1) px_ready = 1'($urandom_range(0, 1));
            else           px_ready = (mode == 2 && cyc < 20) ? 1'b0 : 1'b1;
            start = 1'b0;
            if (restart_at >= 0 && !restarted && exp_idx == restart_at) begin
               start     = 1'b1;
               restarted = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      start = 1'b0;
      if (!finished) begin
         check_eq("frame_timeout", cyc, -1);
      end else begin
         check_eq("first_px_latency", first_v, 2);
         check_eq("busy_in_done", int'(busy), 0);
         start = (restart_at >= 0) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         start = 1'b0;
         check_eq("done_width", int'(done), 0);
         repeat (3) @(posedge clk);
         #1;
         check_eq("idle_after_done", int'(busy), 0);
         check_eq("done_pulses", done_cnt, 1);
         check_eq("pixel_count", exp_idx, 256);
      end
      $display("[TB] frame %0d mode %0d: %0d pixels, %0d done pulse(s)", frame_no, mode, exp_idx, done_cnt);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      px_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'd0;
      #12;
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_valid", int'(px_valid), 0);
      check_eq("rst_flags", int'({px_sof, px_eol, px_eof}), 0);
      check_eq("rst_data", int'(px_data), 0);
      check_eq("rst_addr", int'(fb_addr), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_eq("idle_busy", int'(busy), 0);
      check_eq("idle_valid", int'(px_valid), 0);
      $display("[TB] reset and idle checked");

      run_frame(0, -1, -1, 1'b1);   // ramp data, full rate
      run_frame(1, -1, -1, 1'b0);   // random backpressure
      run_frame(2, -1, -1, 1'b0);   // long stall right after start
      run_frame(0, 100, -1, 1'b1);  // start at pixel 100 and in the DONE cycle
      run_frame(1, -1, 130, 1'b0);  // reset mid-frame
      run_frame(0, -1, -1, 1'b0);   // fresh frame after reset
      run_frame(1, -1, -1, 1'b1);   // random backpressure, ramp data

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 The module SHALL have parameter LINE_LEN, default 16, giving pixels per line; it SHALL be a power of two from 2 to 256.
REQ-002 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  The reset SHALL be asynchronous and active-high.
REQ-004 start  input  1  A 1-cycle request to scan one frame.
REQ-005 busy  output  1  High from the cycle after an accepted start until the cycle of done.
REQ-006 done  output  1  A 1-cycle pulse after the last pixel handshake.
REQ-007 fb_addr  output  8  The read address to the framebuffer RAM.
REQ-008 fb_dout  input  8  The framebuffer read data; it SHALL be valid one clock after fb_addr is presented.
REQ-009 px_data  output  8  The pixel value.
REQ-010 px_valid  output  1  Pixel valid.
REQ-011 px_ready  input  1  Sink ready; a transfer SHALL occur when px_valid and px_ready are both high.
REQ-012 px_sof  output  1  Qualifies the pixel at index 0 (start of frame).
REQ-013 px_eol  output  1  Qualifies the last pixel of each line.
REQ-014 px_eof  output  1  Qualifies pixel index 255 (end of frame).

Function
REQ-015 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-016 IDLE SHALL go to SCAN on start=1; the read index and pixel index SHALL clear to 0 on that transition.
REQ-017 start while not in IDLE SHALL be ignored, with no restart and no queuing.
REQ-018 SCAN SHALL issue reads at fb_addr = rd_idx in ascending order 0..255, with no wrap and no skips.
REQ-019 A read SHALL be issued in a cycle only if (rd_idx<=255 not yet issued) and (entries in the output buffer + reads in flight) < 2.
REQ-020 The data of a read issued at cycle t SHALL be captured from fb_dout at edge t+1 into a 2-entry FIFO; issue order SHALL be preserved.
REQ-021 fb_addr SHALL hold its last value when no read is issued; the framebuffer SHALL never be written by this block.
REQ-022 px_valid SHALL equal FIFO-not-empty, and px_data SHALL equal the FIFO head.
REQ-023 px_data and px_valid SHALL be registered or FIFO-driven, with no combinational path from fb_dout.
REQ-024 px_data, px_sof, px_eol and px_eof SHALL stay stable while px_valid=1 and px_ready=0.
REQ-025 With px_ready held at 1, the first pixel SHALL appear 2 cycles after entering SCAN, at 1 pixel per clock thereafter.
REQ-026 Under backpressure, no pixel SHALL be dropped or duplicated; the buffer SHALL never overflow.
REQ-027 A FIFO push and pop in the same cycle SHALL both take effect.
REQ-028 px_sof SHALL be high when px_idx==0.
REQ-029 px_eol SHALL be high when px_idx[log2(LINE_LEN)-1:0] is all ones.
REQ-030 px_eof SHALL be high when px_idx==255, which also asserts px_eol.
REQ-031 px_idx SHALL increment on each transfer.
REQ-032 The handshake of pixel 255 SHALL move SCAN to DONE.
REQ-033 DONE SHALL assert done=1 for exactly 1 cycle, then go to IDLE.
REQ-034 busy SHALL be 1 in SCAN and 0 in IDLE and DONE.
REQ-035 A start arriving in the DONE cycle SHALL be ignored; start is accepted again from IDLE on the next cycle.
REQ-036 Index counters SHALL be 9 bits wide internally so that the "all 256 issued" condition is unambiguous.
REQ-037 fb_addr SHALL be the low 8 bits of rd_idx.

Reset
REQ-038 On rst=1, outputs SHALL be immediately: busy=0, done=0, px_valid=0, px_sof=0, px_eol=0, px_eof=0, px_data=0, fb_addr=0.
REQ-039 On rst=1, the FSM SHALL go to IDLE and the FIFO and in-flight flag SHALL be emptied.
REQ-040 A reset mid-frame SHALL abandon the frame with no done pulse; the first start after reset release SHALL scan from address 0.
REQ-041 After rst deasserts, the block SHALL idle until start.

Verification
REQ-042 RAM preloaded mem[i]=i, px_ready=1, start pulse -> 256 pixels 0x00..0xFF on consecutive cycles. px_sof on 0x00; px_eol on 0x0F, 0x1F, ..., 0xFF; px_eof on 0xFF only. done 1 cycle after the 0xFF handshake.
REQ-043 px_ready toggled with a pseudo-random pattern (about 50% duty) -> the received sequence equals 0x00..0xFF exactly. px_data is stable during every stall. fb_addr never runs more than 2 ahead of the accepted count.
REQ-044 px_ready=0 for 20 cycles right after start -> fb_addr stops at 1, FIFO holds pixels 0 and 1, and px_data=0x00 is held. Releasing px_ready then delivers 0x00, 0x01, 0x02, ... with no gap after the first.
REQ-045 start pulsed again at pixel 100 and in the DONE cycle -> no effect. Exactly 256 pixels and one done pulse.
REQ-046 rst asserted at pixel 130, asynchronously between edges -> px_valid and busy drop before the next edge. A new start then yields pixel 0x00 with px_sof.
REQ-047 LINE_LEN=256 build -> px_eol is asserted only on pixel 255, together with px_eof.
